// File: rtl/axi_arbiter_2x1_pkg.sv
// axi_arbiter_2x1_pkg: shared AXI3 channel widths, burst encoding and arbiter FSM states
package axi_arbiter_2x1_pkg;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;
    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
endpackage

// File: rtl/axi_arbiter_2x1_if.sv
// axi_arbiter_2x1_if: one AXI3 port (AR, R, AW, W, B channels)
// Modports: master drives AR/AW/W payloads+valids and rready/bready;
//           slave drives arready/awready/wready and R/B payloads+valids.
interface axi_arbiter_2x1_if;
    import axi_arbiter_2x1_pkg::*;
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic [LOCK_W-1:0]  arlock;
    logic [CACHE_W-1:0] arcache;
    logic [PROT_W-1:0]  arprot;
    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;
    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic [LOCK_W-1:0]  awlock;
    logic [CACHE_W-1:0] awcache;
    logic [PROT_W-1:0]  awprot;
    logic               awvalid;
    logic               awready;
    logic [ID_W-1:0]    wid;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               bvalid;
    logic               bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_arbiter_2x1_grant.sv
// axi_arb_grant: two-request arbiter, win_o=1 selects m1
// Ports: req0_i/req1_i requests from m0/m1, last_i previous winner (AXI_ARB_RR_EN only),
//        win_o winner. Macro AXI_ARB_RR_EN selects round-robin, otherwise m1 has fixed priority.
module axi_arb_grant (
    input  logic req0_i,
    input  logic req1_i,
`ifdef AXI_ARB_RR_EN
    input  logic last_i,
`endif
    output logic win_o
);
`ifdef AXI_ARB_RR_EN
    // On a tie the master that did not win last time gets the grant.
    assign win_o = (req0_i && req1_i) ? !last_i : req1_i;
`else
    assign win_o = req1_i || !req0_i;
`endif
endmodule

// File: rtl/axi_arbiter_2x1.sv
// axi_arbiter_2x1: two-master to one-slave AXI3 arbiter with independent read/write FSMs
// Ports: aclk clock; aresetn synchronous active-low reset;
//        m0 (instruction fetch) and m1 (data) master-facing ports; s slave-facing port.
// Macro AXI_ARB_RR_EN: round-robin on ties; otherwise m1 has fixed priority.
module axi_arbiter_2x1 (
    input  logic               aclk,
    input  logic               aresetn,
    axi_arbiter_2x1_if.slave   m0,
    axi_arbiter_2x1_if.slave   m1,
    axi_arbiter_2x1_if.master  s
);
    import axi_arbiter_2x1_pkg::*;
    r_state_e r_state_q, r_state_d;
    w_state_e w_state_q, w_state_d;
    logic rgrant_q, rgrant_d, wgrant_q, wgrant_d;
    logic rwin, wwin, rreq, wreq;
    logic ar_hs, r_done, aw_hs, w_done, b_hs;
    logic ar_o0, ar_o1, r_o0, r_o1, aw_o0, aw_o1, w_o0, w_o1, b_o0, b_o1;
`ifdef AXI_ARB_RR_EN
    logic rlast_q, rlast_d, wlast_q, wlast_d;
`endif
    assign rreq = m0.arvalid || m1.arvalid;
    assign wreq = m0.awvalid || m1.awvalid;
    axi_arb_grant u_rgrant (
        .req0_i (m0.arvalid),
        .req1_i (m1.arvalid),
`ifdef AXI_ARB_RR_EN
        .last_i (rlast_q),
`endif
        .win_o  (rwin)
    );
    axi_arb_grant u_wgrant (
        .req0_i (m0.awvalid),
        .req1_i (m1.awvalid),
`ifdef AXI_ARB_RR_EN
        .last_i (wlast_q),
`endif
        .win_o  (wwin)
    );
    // Per-phase ownership strobes; everything below is gated by these.
    assign ar_o0 = r_state_q == R_ADDR && !rgrant_q;
    assign ar_o1 = r_state_q == R_ADDR &&  rgrant_q;
    assign r_o0  = r_state_q == R_DATA && !rgrant_q;
    assign r_o1  = r_state_q == R_DATA &&  rgrant_q;
    assign aw_o0 = w_state_q == W_ADDR && !wgrant_q;
    assign aw_o1 = w_state_q == W_ADDR &&  wgrant_q;
    assign w_o0  = w_state_q == W_DATA && !wgrant_q;
    assign w_o1  = w_state_q == W_DATA &&  wgrant_q;
    assign b_o0  = w_state_q == W_RESP && !wgrant_q;
    assign b_o1  = w_state_q == W_RESP &&  wgrant_q;
    assign ar_hs  = s.arvalid && s.arready;
    assign r_done = s.rvalid && s.rready && s.rlast;
    assign aw_hs  = s.awvalid && s.awready;
    assign w_done = s.wvalid && s.wready && s.wlast;
    assign b_hs   = s.bvalid && s.bready;
    always_comb begin
        r_state_d = r_state_q == R_IDLE ? (rreq ? R_ADDR : R_IDLE) :
                    r_state_q == R_ADDR ? (ar_hs ? R_DATA : R_ADDR) :
                    (r_done ? R_IDLE : R_DATA);
        w_state_d = w_state_q == W_IDLE ? (wreq ? W_ADDR : W_IDLE) :
                    w_state_q == W_ADDR ? (aw_hs ? W_DATA : W_ADDR) :
                    w_state_q == W_DATA ? (w_done ? W_RESP : W_DATA) :
                    (b_hs ? W_IDLE : W_RESP);
        rgrant_d = (r_state_q == R_IDLE && rreq) ? rwin : rgrant_q;
        wgrant_d = (w_state_q == W_IDLE && wreq) ? wwin : wgrant_q;
`ifdef AXI_ARB_RR_EN
        rlast_d = (r_state_q == R_IDLE && rreq) ? rwin : rlast_q;
        wlast_d = (w_state_q == W_IDLE && wreq) ? wwin : wlast_q;
`endif
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rgrant_q  <= 1'b1;
            wgrant_q  <= 1'b1;
`ifdef AXI_ARB_RR_EN
            rlast_q   <= 1'b0;
            wlast_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rgrant_q  <= rgrant_d;
            wgrant_q  <= wgrant_d;
`ifdef AXI_ARB_RR_EN
            rlast_q   <= rlast_d;
            wlast_q   <= wlast_d;
`endif
        end
    end
    // AR: owner's address phase toward the slave, zero when nobody owns it.
    assign s.arid    = ar_o1 ? m1.arid    : ar_o0 ? m0.arid    : '0;
    assign s.araddr  = ar_o1 ? m1.araddr  : ar_o0 ? m0.araddr  : '0;
    assign s.arlen   = ar_o1 ? m1.arlen   : ar_o0 ? m0.arlen   : '0;
    assign s.arsize  = ar_o1 ? m1.arsize  : ar_o0 ? m0.arsize  : '0;
    assign s.arburst = ar_o1 ? m1.arburst : ar_o0 ? m0.arburst : '0;
    assign s.arlock  = ar_o1 ? m1.arlock  : ar_o0 ? m0.arlock  : '0;
    assign s.arcache = ar_o1 ? m1.arcache : ar_o0 ? m0.arcache : '0;
    assign s.arprot  = ar_o1 ? m1.arprot  : ar_o0 ? m0.arprot  : '0;
    assign s.arvalid = ar_o1 ? m1.arvalid : ar_o0 && m0.arvalid;
    assign m0.arready = ar_o0 && s.arready;
    assign m1.arready = ar_o1 && s.arready;
    // R: routed by the registered grant only; the ID is passed through untouched.
    assign m0.rid    = r_o0 ? s.rid   : '0;
    assign m0.rdata  = r_o0 ? s.rdata : '0;
    assign m0.rresp  = r_o0 ? s.rresp : '0;
    assign m0.rlast  = r_o0 && s.rlast;
    assign m0.rvalid = r_o0 && s.rvalid;
    assign m1.rid    = r_o1 ? s.rid   : '0;
    assign m1.rdata  = r_o1 ? s.rdata : '0;
    assign m1.rresp  = r_o1 ? s.rresp : '0;
    assign m1.rlast  = r_o1 && s.rlast;
    assign m1.rvalid = r_o1 && s.rvalid;
    assign s.rready  = r_o1 ? m1.rready : r_o0 && m0.rready;
    // AW
    assign s.awid    = aw_o1 ? m1.awid    : aw_o0 ? m0.awid    : '0;
    assign s.awaddr  = aw_o1 ? m1.awaddr  : aw_o0 ? m0.awaddr  : '0;
    assign s.awlen   = aw_o1 ? m1.awlen   : aw_o0 ? m0.awlen   : '0;
    assign s.awsize  = aw_o1 ? m1.awsize  : aw_o0 ? m0.awsize  : '0;
    assign s.awburst = aw_o1 ? m1.awburst : aw_o0 ? m0.awburst : '0;
    assign s.awlock  = aw_o1 ? m1.awlock  : aw_o0 ? m0.awlock  : '0;
    assign s.awcache = aw_o1 ? m1.awcache : aw_o0 ? m0.awcache : '0;
    assign s.awprot  = aw_o1 ? m1.awprot  : aw_o0 ? m0.awprot  : '0;
    assign s.awvalid = aw_o1 ? m1.awvalid : aw_o0 && m0.awvalid;
    assign m0.awready = aw_o0 && s.awready;
    assign m1.awready = aw_o1 && s.awready;
    // W only opens after the AW handshake, so early beats see wready=0.
    assign s.wid    = w_o1 ? m1.wid   : w_o0 ? m0.wid   : '0;
    assign s.wdata  = w_o1 ? m1.wdata : w_o0 ? m0.wdata : '0;
    assign s.wstrb  = w_o1 ? m1.wstrb : w_o0 ? m0.wstrb : '0;
    assign s.wlast  = w_o1 ? m1.wlast  : w_o0 && m0.wlast;
    assign s.wvalid = w_o1 ? m1.wvalid : w_o0 && m0.wvalid;
    assign m0.wready = w_o0 && s.wready;
    assign m1.wready = w_o1 && s.wready;
    // B
    assign m0.bid    = b_o0 ? s.bid   : '0;
    assign m0.bresp  = b_o0 ? s.bresp : '0;
    assign m0.bvalid = b_o0 && s.bvalid;
    assign m1.bid    = b_o1 ? s.bid   : '0;
    assign m1.bresp  = b_o1 ? s.bresp : '0;
    assign m1.bvalid = b_o1 && s.bvalid;
    assign s.bready  = b_o1 ? m1.bready : b_o0 && m0.bready;
endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// tb_axi_arbiter_2x1: directed table-driven bench for axi_arbiter_2x1
module tb_axi_arbiter_2x1;
    import axi_arbiter_2x1_pkg::*;
`ifdef AXI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] A1 = 32'h8000_0000;
    localparam logic [31:0] RD = 32'h3C1D_BFC0;
    logic aclk, aresetn;
    int checks, errors;
    axi_arbiter_2x1_if m0_if ();
    axi_arbiter_2x1_if m1_if ();
    axi_arbiter_2x1_if s_if ();
    axi_arbiter_2x1 dut (.aclk(aclk), .aresetn(aresetn), .m0(m0_if), .m1(m1_if), .s(s_if));
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    // in = {m0 arvalid, m1 arvalid, s arready, s rvalid, s rlast}
    // ex = {s arvalid, m0 arready, m1 arready, m0 rvalid, m1 rvalid, s rready}
    typedef struct {
        logic [4:0]  in;
        logic [5:0]  ex;
        logic [31:0] addr;
    } rvec_t;
    rvec_t tbl [25];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [14:0] all_vr();
        return {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready,
                m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid,
                m0_if.awready, m1_if.awready, m0_if.wready, m1_if.wready,
                m0_if.bvalid, m1_if.bvalid};
    endfunction
    initial begin
        checks = 0;
        errors = 0;
        tbl = '{
            '{5'b10000, 6'b000000, 32'h0},
            '{5'b10000, 6'b100000, A0},
            '{5'b10000, 6'b100000, A0},
            '{5'b10100, 6'b110000, A0},
            '{5'b00011, 6'b000101, 32'h0},
            '{5'b00000, 6'b000000, 32'h0},
            '{5'b11000, 6'b000000, 32'h0},
            '{5'b11100, 6'b101000, A1},
            '{5'b11011, 6'b000011, 32'h0},
            '{5'b11000, 6'b000000, 32'h0},
            '{5'b11100, RR ? 6'b110000 : 6'b101000, RR ? A0 : A1},
            '{5'b11011, RR ? 6'b000101 : 6'b000011, 32'h0},
            '{5'b10000, 6'b000000, 32'h0},
            '{5'b10100, 6'b110000, A0},
            '{5'b00011, 6'b000101, 32'h0},
            '{5'b01000, 6'b000000, 32'h0},
            '{5'b01100, 6'b101000, A1},
            '{5'b10010, 6'b000011, 32'h0},
            '{5'b10010, 6'b000011, 32'h0},
            '{5'b10010, 6'b000011, 32'h0},
            '{5'b10011, 6'b000011, 32'h0},
            '{5'b10000, 6'b000000, 32'h0},
            '{5'b10100, 6'b110000, A0},
            '{5'b00011, 6'b000101, 32'h0},
            '{5'b00000, 6'b000000, 32'h0}
        };
        {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst, m0_if.arlock, m0_if.arcache, m0_if.arprot, m0_if.arvalid} = '0;
        {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst, m1_if.arlock, m1_if.arcache, m1_if.arprot, m1_if.arvalid} = '0;
        {m0_if.awid, m0_if.awaddr, m0_if.awlen, m0_if.awsize, m0_if.awburst, m0_if.awlock, m0_if.awcache, m0_if.awprot, m0_if.awvalid} = '0;
        {m1_if.awid, m1_if.awaddr, m1_if.awlen, m1_if.awsize, m1_if.awburst, m1_if.awlock, m1_if.awcache, m1_if.awprot, m1_if.awvalid} = '0;
        {m0_if.wid, m0_if.wdata, m0_if.wstrb, m0_if.wlast, m0_if.wvalid} = '0;
        {m1_if.wid, m1_if.wdata, m1_if.wstrb, m1_if.wlast, m1_if.wvalid} = '0;
        m0_if.rready = 1'b1; m1_if.rready = 1'b1; m0_if.bready = 1'b1; m1_if.bready = 1'b1;
        s_if.arready = 1'b0; s_if.awready = 1'b0; s_if.wready = 1'b0;
        {s_if.rid, s_if.rresp, s_if.rlast, s_if.rvalid} = '0;
        {s_if.bid, s_if.bresp, s_if.bvalid} = '0;
        s_if.rdata = RD;
        m0_if.arid = 4'h1; m0_if.araddr = A0; m0_if.arsize = 3'd2; m0_if.arburst = BURST_INCR;
        m1_if.arid = 4'h2; m1_if.araddr = A1; m1_if.arlen = 4'd3; m1_if.arsize = 3'd2; m1_if.arburst = BURST_INCR;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #2;
        chk("reset_outputs", all_vr(), 0);
        aresetn = 1'b1;
        // read-path vectors: single read, tie, second tie, burst
        for (int i = 0; i < 25; i++) begin
            @(negedge aclk);
            {m0_if.arvalid, m1_if.arvalid, s_if.arready, s_if.rvalid, s_if.rlast} = tbl[i].in;
            #2;
            chk($sformatf("rd%0d_ctl", i),
                {s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready}, tbl[i].ex);
            if (tbl[i].ex[5]) begin
                chk($sformatf("rd%0d_araddr", i), s_if.araddr, tbl[i].addr);
                chk($sformatf("rd%0d_arlen", i), s_if.arlen, tbl[i].addr == A1 ? 4'd3 : 4'd0);
            end
            if (tbl[i].ex[2]) chk($sformatf("rd%0d_m0_rdata", i), m0_if.rdata, RD);
            if (tbl[i].ex[1]) chk($sformatf("rd%0d_m1_rdata", i), m1_if.rdata, RD);
        end
        // m1 write with slow wready, concurrent m0 read
        @(negedge aclk);
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h8000_1000; m1_if.awid = 4'h5; m1_if.awburst = BURST_INCR;
        m1_if.wvalid = 1'b1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1'b1; m1_if.wid = 4'h5;
        m0_if.arvalid = 1'b1;
        #2;
        chk("w0_idle", {s_if.awvalid, m1_if.wready, s_if.wvalid, s_if.arvalid}, 0);
        @(negedge aclk);
        s_if.awready = 1'b1;
        #2;
        chk("w1_aw", {s_if.awvalid, m1_if.awready, m0_if.awready, m1_if.wready, s_if.wvalid}, 5'b11000);
        chk("w1_awaddr", {s_if.awaddr, s_if.awid}, {32'h8000_1000, 4'h5});
        chk("w1_ar", {s_if.arvalid, m0_if.arready}, 2'b10);
        @(negedge aclk);
        m1_if.awvalid = 1'b0; s_if.awready = 1'b0; s_if.arready = 1'b1;
        #2;
        chk("w2_w", {s_if.wvalid, m1_if.wready, m0_if.wready}, 3'b100);
        chk("w2_wpay", {s_if.wdata, s_if.wstrb, s_if.wid}, {32'hDEAD_BEEF, 4'hF, 4'h5});
        chk("w2_ar", {s_if.arvalid, m0_if.arready}, 2'b11);
        @(negedge aclk);
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
        #2;
        chk("w3_r", {m0_if.rvalid, m1_if.rvalid, s_if.rready, s_if.wvalid, m1_if.wready}, 5'b10110);
        chk("w3_rdata", m0_if.rdata, RD);
        @(negedge aclk);
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        #2;
        chk("w4_w", {s_if.wvalid, m1_if.wready, s_if.arvalid, m0_if.rvalid}, 4'b1000);
        chk("w4_wdata", s_if.wdata, 32'hDEAD_BEEF);
        @(negedge aclk);
        s_if.wready = 1'b1;
        #2;
        chk("w5_w", {s_if.wvalid, m1_if.wready, s_if.wlast}, 3'b111);
        @(negedge aclk);
        s_if.wready = 1'b0; m1_if.wvalid = 1'b0; s_if.bvalid = 1'b1; s_if.bresp = 2'b01; s_if.bid = 4'h5;
        #2;
        chk("w6_b", {m1_if.bvalid, m0_if.bvalid, s_if.bready, s_if.wvalid}, 4'b1010);
        chk("w6_bpay", {m1_if.bid, m1_if.bresp}, {4'h5, 2'b01});
        @(negedge aclk);
        s_if.bvalid = 1'b0;
        #2;
        chk("w7_idle", all_vr(), 0);
        // reset during R_DATA with s_rvalid high, then a fresh m0 read
        @(negedge aclk);
        m0_if.arvalid = 1'b1;
        #2;
        @(negedge aclk);
        s_if.arready = 1'b1;
        #2;
        chk("rs_ar", {s_if.arvalid, m0_if.arready}, 2'b11);
        @(negedge aclk);
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rlast = 1'b0; aresetn = 1'b0;
        #2;
        chk("rs_pre", {m0_if.rvalid, s_if.rready}, 2'b11);
        @(negedge aclk);
        aresetn = 1'b1;
        #2;
        chk("rs_post", all_vr(), 0);
        @(negedge aclk);
        s_if.rvalid = 1'b0; m0_if.arvalid = 1'b1;
        #2;
        chk("rs_idle", all_vr(), 0);
        @(negedge aclk);
        s_if.arready = 1'b1;
        #2;
        chk("rs_ar2", {s_if.arvalid, m0_if.arready, s_if.araddr}, {2'b11, A0});
        @(negedge aclk);
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
        #2;
        chk("rs_r2", {m0_if.rvalid, m1_if.rvalid, s_if.rready, m0_if.rdata, m0_if.rresp}, {3'b101, RD, 2'b00});
        @(negedge aclk);
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        #2;
        chk("rs_done", all_vr(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_arbiter_2x1.md
# axi_arbiter_2x1

Two-master to one-slave AXI3 arbiter placed directly downstream of the CPU-side AXI master interfaces. Port m0 carries instruction fetch and port m1 carries data load/store; the single s port drives the SoC bus. Read and write paths are arbitrated independently, and each holds one outstanding single-owner transaction at a time. Once a grant is registered, all channel payloads, valids and readies are forwarded combinationally.

## Interface
Parameters: none. Widths come from the shared defines: ID 4, ADDR 32, Data 32, Len 4, Size 3, Burst 2, Lock 2, Cache 4, Prot 3, Resp 2.

- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- mX_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot, mX_arvalid  in  4/32/4/3/2/2/4/3/1  master X read address (X = 0, 1)
- mX_arready  out  1  master X AR ready
- mX_rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  master X read data
- mX_rready  in  1  master X R ready
- mX_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot, mX_awvalid  in  same widths as AR  master X write address
- mX_awready  out  1
- mX_wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  master X write data
- mX_wready  out  1
- mX_bid/bresp/bvalid  out  4/2/1  master X write response
- mX_bready  in  1
- s_ar*, s_aw*, s_w*, s_rready, s_bready  out  mirror of the master-side inputs, toward the slave
- s_arready, s_awready, s_wready, s_r*, s_b*  in  mirror of the master-side outputs, from the slave

## Operation
Read FSM:
- R_IDLE: if m1_arvalid or m0_arvalid, register rgrant (the winner) and go to R_ADDR. Without requests, stay.
- R_ADDR: s_ar* = owner's ar*. Owner's arready = s_arready. On s_arvalid&&s_arready go to R_DATA.
- R_DATA: owner's r* = s_r*, s_rready = owner's rready. On s_rvalid&&s_rready&&s_rlast go to R_IDLE.

Write FSM:
- W_IDLE: arbitrate awvalid the same way, register wgrant, go to W_ADDR.
- W_ADDR: forward AW. On handshake go to W_DATA.
- W_DATA: forward W. On a handshake with wlast=1 go to W_RESP.
- W_RESP: forward B. On s_bvalid&&s_bready go to W_IDLE.

Gating and pass-through rules:
- The non-owner and all idle-state outputs are held at 0: valids, readies, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready.
- IDs pass through unmodified. Responses route by the registered grant, never by ID.
- W is never forwarded before the AW handshake. W beats presented early stall with wready=0.
- Default priority is fixed: m1 (data) beats m0 (fetch) on simultaneous requests.
- Read and write FSMs are fully independent. m0 reading while m1 writes proceeds concurrently.

## Timing
- Reset: all outputs 0, both FSMs idle, grants = m1.
- Reset asserted mid-transaction aborts it: FSMs return to IDLE and all valids/readies are 0 at the following edge.
- Arbitration latency: 1 cycle. A request seen in IDLE reaches s_arvalid/s_awvalid in the next cycle.
- Forwarding adds 0 cycles. A read transaction returns to IDLE on the edge after the rlast handshake, so back-to-back grants are spaced by 1 idle cycle.
- A master dropping valid before its handshake violates AXI. The arbiter keeps the grant and waits.
- arlen/awlen > 0 bursts are supported. Termination relies solely on rlast/wlast.

## Configuration
- AXI_ARB_RR_EN defined: round-robin arbitration.
  - Each FSM keeps a last-winner bit, updated when the grant is registered in IDLE.
  - On simultaneous requests the master that did not win last is granted.
  - The bit resets to "m0 last", so m1 wins the first tie.
- AXI_ARB_RR_EN undefined: fixed priority, m1 over m0. No last-winner state is implemented.

## Structure
- Shared defines (axi_defines.v) carry the channel widths, the INCR encoding, and the FSM state encodings (`ARB_R_IDLE`, `ARB_R_ADDR`, `ARB_R_DATA`, `ARB_W_IDLE`, `ARB_W_ADDR`, `ARB_W_DATA`, `ARB_W_RESP`).
- One sub-module: axi_arb_grant (two request bits plus last-winner in, one-bit winner out, round-robin logic under the macro). It is instantiated twice, once for read and once for write.

## Test plan
- Single m0 read at 0x1FC00000; slave gives arready after 2 cycles and rdata 0x3C1DBFC0 with rlast -> m0 receives rdata 0x3C1DBFC0 with rresp 0; m1 rvalid stays 0 throughout; read FSM is idle 1 cycle after rlast.
- m0 and m1 assert arvalid in the same cycle -> m1 is forwarded first, m0 follows. With AXI_ARB_RR_EN, a second tie grants m0.
- m1 write of 0xDEADBEEF, wstrb 0xF, to 0x80001000; slave holds wready=0 for 3 cycles -> s_wdata is stable, bresp is routed to m1 only, and m0 bvalid stays 0.
- m0 read concurrent with m1 write, slave responding interleaved -> both complete with correct data and response; neither FSM stalls the other.
- Reset pulsed during R_DATA with s_rvalid=1 -> next cycle all s_/m_ valids and readies are 0; a fresh m0 read afterwards completes normally.
- 4-beat INCR read (arlen 3) for m1 -> all 4 beats are forwarded and the grant is released only after the rlast beat.
